// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared constants and enums for the 512x36 1RW SRAM controller
package sram_ctrl_pkg;

   localparam int DEPTH  = 512;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 36;

   typedef enum logic {
      INIT,
      RUN
   } state_e;

   typedef enum logic {
      PRIO_WRITE,
      PRIO_READ
   } prio_e;

endpackage

// File: rtl/sram_rsp_fifo2.sv
// rtl/sram_rsp_fifo2.sv - 2-entry in-order read response buffer
module sram_rsp_fifo2
   import sram_ctrl_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [1:0]        count,
   output logic [DATA_W-1:0] head_data
);

   logic [DATA_W-1:0] mem_q [0:1];
   logic [DATA_W-1:0] mem_d [0:1];
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        count_q, count_d;

   // Next-state: write at the tail, advance the head on pop, track occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Storage and pointers; entries reset to zero so the idle head reads 0.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count     = count_q;
   assign head_data = mem_q[rd_ptr_q];

   // The read credit rule upstream must keep a push from landing on a full buffer.
   a_no_overflow : assert property (@(posedge clock) disable iff (!reset_n)
      !(push && !pop && (count_q == 2'd2)));

endmodule

// File: rtl/sram_1rw_arbiter_512x36.sv
// rtl/sram_1rw_arbiter_512x36.sv - clear sequencer and round-robin arbiter for a 512x36 1RW SRAM
module sram_1rw_arbiter_512x36
   import sram_ctrl_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              w_valid,
   output logic              w_ready,
   input  logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_data,
   input  logic              r_valid,
   output logic              r_ready,
   input  logic [ADDR_W-1:0] r_addr,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              init_done,
   output logic [ADDR_W-1:0] sram_addr,
   output logic              sram_en,
   output logic              sram_wmode,
   output logic [DATA_W-1:0] sram_wdata,
   input  logic [DATA_W-1:0] sram_rdata
);

   state_e            state_q, state_d;
   prio_e             prio_q, prio_d;
   logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
   logic              inflight_q, inflight_d;

   logic [1:0]        fifo_count;
   logic              pop;
   logic [2:0]        occupancy;
   logic              w_elig;
   logic              r_elig;
   logic              grant_w;
   logic              grant_r;

   assign rsp_valid = (fifo_count != 2'd0);
   assign pop       = rsp_valid & rsp_ready;

   // Reads already owed a buffer slot: buffered plus the one in the macro, less the one leaving now.
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight_q} - {2'b00, pop};
   assign w_elig    = w_valid;
   assign r_elig    = r_valid && (occupancy <= 3'd1);

   // Sequencing and arbitration: INIT clears the array, RUN grants one side per cycle.
   always_comb begin
      state_d    = state_q;
      prio_d     = prio_q;
      init_cnt_d = init_cnt_q;
      grant_w    = 1'b0;
      grant_r    = 1'b0;
      init_done  = 1'b0;
      sram_en    = 1'b0;
      sram_wmode = 1'b0;
      sram_addr  = '0;
      sram_wdata = '0;
      if (state_q == INIT) begin
         sram_en    = 1'b1;
         sram_wmode = 1'b1;
         sram_addr  = init_cnt_q;
         if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = RUN;
         end else begin
            init_cnt_d = init_cnt_q + 1'b1;
         end
      end else begin
         init_done = 1'b1;
         if (w_elig && r_elig) begin
            if (prio_q == PRIO_WRITE) begin
               grant_w = 1'b1;
               prio_d  = PRIO_READ;
            end else begin
               grant_r = 1'b1;
               prio_d  = PRIO_WRITE;
            end
         end else if (w_elig) begin
            grant_w = 1'b1;
         end else if (r_elig) begin
            grant_r = 1'b1;
         end
         if (grant_w) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b1;
            sram_addr  = w_addr;
            sram_wdata = w_data;
         end else if (grant_r) begin
            sram_en    = 1'b1;
            sram_wmode = 1'b0;
            sram_addr  = r_addr;
         end
      end
      inflight_d = grant_r;
   end

   assign w_ready = grant_w;
   assign r_ready = grant_r;

   // Controller state; reset restarts the clear and forgets any read in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= INIT;
         prio_q     <= PRIO_WRITE;
         init_cnt_q <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         init_cnt_q <= init_cnt_d;
         inflight_q <= inflight_d;
      end
   end

   // Macro read data is only meaningful the cycle after a read strobe, so capture it then.
   sram_rsp_fifo2 u_rsp_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (inflight_q),
      .push_data (sram_rdata),
      .pop       (pop),
      .count     (fifo_count),
      .head_data (rsp_data)
   );

endmodule

// File: tb/tb_sram_1rw_arbiter_512x36.sv
// tb/tb_sram_1rw_arbiter_512x36.sv - self-checking bench for the 512x36 1RW SRAM controller
module tb_sram_1rw_arbiter_512x36;

   localparam int DEPTH  = 512;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 36;

   logic              clock = 1'b0;
   logic              reset_n = 1'b0;
   logic              w_valid = 1'b0;
   logic              w_ready;
   logic [ADDR_W-1:0] w_addr = '0;
   logic [DATA_W-1:0] w_data = '0;
   logic              r_valid = 1'b0;
   logic              r_ready;
   logic [ADDR_W-1:0] r_addr = '0;
   logic              rsp_valid;
   logic              rsp_ready = 1'b1;
   logic [DATA_W-1:0] rsp_data;
   logic              init_done;
   logic [ADDR_W-1:0] sram_addr;
   logic              sram_en;
   logic              sram_wmode;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata = '0;

   int n_checks = 0;
   int n_pass   = 0;

   sram_1rw_arbiter_512x36 dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .w_valid    (w_valid),
      .w_ready    (w_ready),
      .w_addr     (w_addr),
      .w_data     (w_data),
      .r_valid    (r_valid),
      .r_ready    (r_ready),
      .r_addr     (r_addr),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_data   (rsp_data),
      .init_done  (init_done),
      .sram_addr  (sram_addr),
      .sram_en    (sram_en),
      .sram_wmode (sram_wmode),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata)
   );

   always #5 clock = ~clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      else n_pass++;
   endtask

   // Behavioural macro: read data is junk except in the cycle after a read strobe.
   logic [DATA_W-1:0] smem [0:DEPTH-1];
   always @(posedge clock) begin
      if (sram_en && sram_wmode) smem[sram_addr] <= sram_wdata;
      if (sram_en && !sram_wmode) sram_rdata <= smem[sram_addr];
      else sram_rdata <= DATA_W'({$urandom(), $urandom()});
   end

   // Reference model: array contents, pending responses with earliest delivery cycle, priority.
   typedef struct {
      logic [DATA_W-1:0] d;
      int                avail;
   } pend_t;

   logic [DATA_W-1:0] mdl_mem [0:DEPTH-1];
   pend_t             exp_q[$];
   logic [DATA_W-1:0] rx_log[$];
   int                post_cyc = 0;
   bit                prio_read = 1'b0;

   always @(negedge clock) begin
      bit ev, pop_e, re, we, gw, gr;
      int outstanding;
      if (!reset_n) begin
         chk("rst_w_ready", w_ready, 0);
         chk("rst_r_ready", r_ready, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_init_done", init_done, 0);
         chk("rst_sram_en", sram_en, 1);
         chk("rst_sram_wmode", sram_wmode, 1);
         chk("rst_sram_addr", sram_addr, 0);
         chk("rst_sram_wdata", sram_wdata, 0);
         chk("rst_rsp_data", rsp_data, 0);
         exp_q.delete();
         prio_read = 1'b0;
         post_cyc  = 0;
         for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
      end else if (post_cyc < DEPTH) begin
         chk("init_sram_en", sram_en, 1);
         chk("init_sram_wmode", sram_wmode, 1);
         chk("init_sram_addr", sram_addr, 64'(post_cyc));
         chk("init_sram_wdata", sram_wdata, 0);
         chk("init_done_low", init_done, 0);
         chk("init_readies", {w_ready, r_ready}, 0);
         post_cyc++;
      end else begin
         outstanding = exp_q.size();
         ev    = (outstanding > 0) && (exp_q[0].avail <= post_cyc);
         pop_e = ev && rsp_ready;
         we    = w_valid;
         re    = r_valid && ((outstanding - int'(pop_e)) <= 1);
         gw    = we && (!re || !prio_read);
         gr    = re && !gw;
         chk("init_done_high", init_done, 1);
         chk("rsp_valid", rsp_valid, ev);
         if (ev) chk("rsp_data", rsp_data, exp_q[0].d);
         chk("w_ready", w_ready, gw);
         chk("r_ready", r_ready, gr);
         chk("sram_en", sram_en, gw || gr);
         chk("sram_wdata", sram_wdata, gw ? w_data : '0);
         if (gw || gr) begin
            chk("sram_wmode", sram_wmode, gw);
            chk("sram_addr", sram_addr, gw ? w_addr : r_addr);
         end
         if (rsp_valid && rsp_ready) rx_log.push_back(rsp_data);
         if (pop_e) void'(exp_q.pop_front());
         if (we && re) prio_read = !prio_read;
         if (gw) mdl_mem[w_addr] = w_data;
         if (gr) exp_q.push_back('{d: mdl_mem[r_addr], avail: post_cyc + 2});
         post_cyc++;
      end
   end

   task automatic wait_init(output int cyc);
      cyc = 0;
      while (!init_done && cyc < 600) begin
         @(posedge clock); #1;
         cyc++;
      end
   endtask

   task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
      bit ok = 1'b0;
      w_valid = 1'b1; w_addr = a; w_data = d;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clock);
         if (w_ready) ok = 1'b1;
         @(posedge clock); #1;
      end
      w_valid = 1'b0;
      chk("write_accept", ok, 1);
   endtask

   task automatic do_read(input logic [ADDR_W-1:0] a);
      bit ok = 1'b0;
      r_valid = 1'b1; r_addr = a;
      for (int k = 0; k < 50 && !ok; k++) begin
         @(negedge clock);
         if (r_ready) ok = 1'b1;
         @(posedge clock); #1;
      end
      r_valid = 1'b0;
      chk("read_accept", ok, 1);
   endtask

   task automatic wait_rx(input int n);
      int k = 0;
      while (rx_log.size() < n && k < 100) begin
         @(posedge clock); #1;
         k++;
      end
      chk("rx_count", rx_log.size(), n);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (exp_q.size() != 0 && k < 100) begin
         @(posedge clock); #1;
         k++;
      end
      chk("drain", exp_q.size(), 0);
   endtask

   initial begin
      int    cyc, acc, base;
      string order;
      repeat (3) @(posedge clock);
      #1 reset_n = 1'b1;
      wait_init(cyc);
      chk("init_cycles", cyc, 512);

      // Cleared array reads zero.
      do_read(9'd5);
      wait_rx(1);
      chk("clear_read5", rx_log[0], 0);

      // Write then read the same address on the next cycle; response two cycles after accept.
      do_write(9'd3, 36'h123456789);
      r_valid = 1'b1; r_addr = 9'd3;
      @(negedge clock);
      chk("lat_accept", r_ready, 1);
      @(posedge clock); #1;
      r_valid = 1'b0;
      @(negedge clock);
      chk("lat_c1_valid", rsp_valid, 0);
      @(negedge clock);
      chk("lat_c2_valid", rsp_valid, 1);
      chk("lat_c2_data", rsp_data, 36'h123456789);
      @(posedge clock); #1;
      wait_idle();

      // Saturated contention alternates starting with the write side.
      order = "";
      w_valid = 1'b1; w_addr = 9'd10; w_data = 36'hABC;
      r_valid = 1'b1; r_addr = 9'd11;
      for (int k = 0; k < 6; k++) begin
         @(negedge clock);
         chk("one_ready", 64'(w_ready) + 64'(r_ready), 1);
         if (w_ready) order = {order, "W"};
         if (r_ready) order = {order, "R"};
         @(posedge clock); #1;
      end
      w_valid = 1'b0; r_valid = 1'b0;
      chk("contention_order", (order == "WRWRWR") ? 1 : 0, 1);
      wait_idle();

      // Backpressure: only two reads outstanding while the response side stalls.
      do_write(9'd1, 36'h0A1);
      do_write(9'd2, 36'h0B2);
      wait_idle();
      base = rx_log.size();
      rsp_ready = 1'b0;
      acc = 0;
      r_valid = 1'b1; r_addr = 9'd1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clock);
         if (r_ready) acc++;
         @(posedge clock); #1;
         r_addr = ADDR_W'(acc + 1);
      end
      #3;
      chk("bp_accepted", acc, 2);
      chk("bp_r_ready_low", r_ready, 0);
      rsp_ready = 1'b1;
      for (int k = 0; k < 20 && acc < 3; k++) begin
         @(negedge clock);
         if (r_ready) acc++;
         @(posedge clock); #1;
         r_addr = ADDR_W'(acc + 1);
      end
      r_valid = 1'b0;
      chk("bp_total", acc, 3);
      wait_rx(base + 3);
      chk("bp_rx0", rx_log[base], 36'h0A1);
      chk("bp_rx1", rx_log[base + 1], 36'h0B2);
      chk("bp_rx2", rx_log[base + 2], 36'h123456789);

      // Streaming reads sustain one per cycle.
      base = rx_log.size();
      acc = 0;
      for (int i = 0; i < 16; i++) begin
         r_valid = 1'b1; r_addr = ADDR_W'(i);
         @(negedge clock);
         if (r_ready) acc++;
         @(posedge clock); #1;
      end
      r_valid = 1'b0;
      chk("stream_accepted", acc, 16);
      wait_rx(base + 16);
      chk("stream_rx3", rx_log[base + 3], 36'h123456789);

      // Reset with a full buffer drops rsp_valid at once and re-clears the array.
      rsp_ready = 1'b0;
      do_read(9'd3);
      do_read(9'd2);
      repeat (3) @(posedge clock);
      #1;
      chk("pre_reset_valid", rsp_valid, 1);
      #1 reset_n = 1'b0;
      #1;
      chk("reset_async_valid", rsp_valid, 0);
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      rsp_ready = 1'b1;
      wait_init(cyc);
      chk("reinit_cycles", cyc, 512);
      base = rx_log.size();
      do_read(9'd3);
      wait_rx(base + 1);
      chk("reinit_read3", rx_log[base], 0);

      repeat (3) @(posedge clock);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
